oka_clmul_seq: RTL and testbench
================================

# oka_clmul_seq

Parametrised, sequential carry-less (GF(2) polynomial) multiplier and the successor to our fixed 8×8 combinational polynomial-product blocks. Accepts W-bit operands over a valid/ready handshake and computes the (2W−1)-bit XOR-of-ANDs product digit-serially, D bits of `b` per cycle. It can optionally reduce the product modulo a degree-W polynomial, giving a GF(2^W) field multiply. It sits between operand registers and downstream GF datapath stages where area matters more than single-cycle latency.

## Interface
- `W`, 8: operand width in bits; ≥2.
- `D`, 2: digit width processed per CALC cycle; 1 ≤ D ≤ W; W % D == 0, else elaboration error.
- `POLY`, 8'h1B: low W bits of the reduction polynomial; the x^W term is implicit. Used only with `OKA_MOD_REDUCE_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `a` in W: multiplicand.
- `b` in W: multiplier, consumed D bits per cycle, MSB digit first.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block can accept operands.
- `y` out 2W−1: product; stable while `out_valid`.
- `out_valid` out 1: `y` holds a finished result.
- `out_ready` in 1: consumer accepts `y`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, CALC, RED (reduction; present only with the macro), DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`:
  - latch `a` into `a_r` and `b` into `b_r`;
  - clear `acc` (2W−1 bits) and the digit counter;
  - go to CALC.
- CALC, one digit per cycle, Horner form:
  - `acc ← (acc << D) XOR (XOR over i<D of (a_r << i) AND b_r[W−D+i])`;
  - then `b_r ← b_r << D`;
  - bits shifted above 2W−2 are provably zero and are discarded.
- After W/D CALC cycles, go to DONE, or to RED when the macro is defined.
- RED:
  - an index k starts at 2W−2 and steps down by one each cycle;
  - if `acc[k]`=1, then `acc ← acc XOR ({1,POLY} << (k−W))`;
  - after the cycle with k=W, go to DONE. RED lasts W−1 cycles.
- DONE:
  - `out_valid`=1 and `y`=`acc`;
  - on `out_ready`, go to IDLE;
  - otherwise hold, with `y` unchanged.
- `in_ready` is high only in IDLE. There is no overlap: a new operand is never accepted in the cycle that DONE hands off.
- `in_valid` is ignored outside IDLE. Input changes during CALC, RED or DONE have no effect.
- The arithmetic is purely GF(2). Shifts are logical and all additions are XOR. There is no carry anywhere.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `y`=0. State goes to IDLE and the counters clear.
- Reset during CALC, RED or DONE aborts the operation and discards the result. The block is back in IDLE on the next cycle.
- Accept at edge t. Then `out_valid` rises after edge t+W/D without the macro, or after t+W/D+W−1 with it.
- With defaults (W=8, D=2): latency is 4 cycles, or 11 with reduction.
- Throughput is one result per latency+2 cycles when `out_ready` is held high: the accept cycle plus one DONE cycle.
- `out_valid` and `y` stay stable until the cycle in which `out_ready`=1 is sampled, and drop on the following edge.
- With D=W, CALC lasts exactly 1 cycle.

## Configuration
- `OKA_MOD_REDUCE_EN` defined:
  - RED state and `POLY` logic are compiled in;
  - `y[W−1:0]` is the product mod (x^W + POLY) and `y[2W−2:W]`=0.
- Macro undefined:
  - no RED state and no reduction logic;
  - `y` is the full (2W−1)-bit carry-less product;
  - `POLY` is ignored.

## Test plan
- Defaults, no macro: a=8'hFF, b=8'hFF → `y`=15'h5555, with `out_valid` exactly 4 cycles after accept.
- Defaults, no macro: a=8'h03, b=8'h03 → `y`=15'h0005. Then a=8'h80, b=8'h80 → `y`=15'h4000. `in_ready`=0 throughout each operation.
- Macro defined, POLY=8'h1B: a=8'h57, b=8'h83 → `y`=15'h00C1 after 11 cycles. a=8'h01, b=8'hA5 → `y`=15'h00A5.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `y` and `out_valid` stay constant and a pulsed `in_valid` is not accepted. Raise `out_ready` → IDLE the next cycle.
- Reset mid-CALC: assert `rst` 2 cycles after accept → next cycle IDLE, `out_valid`=0, `y`=0. A fresh a=8'h02, b=8'h03 → `y`=15'h0006.
- Parameter sweep with W=16 and D∈{1,4,16}: 1000 random operands compared against a software clmul reference, with latency = W/D cycles for each D.

Source files
------------

// File: rtl/oka_clmul_seq_if.sv
// Operand/result handshake bundle for oka_clmul_seq.
// The master drives operands and accepts results; the multiplier is the slave.
interface oka_clmul_seq_if #(
    parameter int W = 8
) ();
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-2:0] y;
    logic           out_valid;
    logic           out_ready;
    logic           busy;

    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, y, out_valid, busy
    );

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, y, out_valid, busy
    );
endinterface

// File: rtl/oka_clmul_seq.sv
// Digit-serial GF(2) multiplier, D bits of b per cycle, optional mod-POLY reduction (OKA_MOD_REDUCE_EN).
// Latency: W/D cycles after accept, plus W-1 reduction cycles when OKA_MOD_REDUCE_EN is defined.
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module oka_clmul_seq #(
    parameter int           W    = 8,
    parameter int           D    = 2,
    parameter logic [W-1:0] POLY = 8'h1B
) (
    input  logic             clk,
    input  logic             rst,
    oka_clmul_seq_if.slave   bus
);
    localparam int NDIG = W / D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int AW   = 2 * W - 1;

    if (W < 2 || D < 1 || D > W || (W % D) != 0) begin : g_bad_param
        $error("oka_clmul_seq: need W>=2, 1<=D<=W and W %% D == 0");
    end
    if ($bits(POLY) != W) begin : g_bad_poly
        $error("oka_clmul_seq: POLY must be W bits wide");
    end

`ifdef OKA_MOD_REDUCE_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_RED = 2'd2, S_DONE = 2'd3} state_e;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd3} state_e;
`endif

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   pp;
    logic [AW-1:0]   calc_acc;

    // Top digit of b selects shifted copies of a; Horner step keeps MSB-first order.
    always_comb begin
        pp = '0;
        for (int i = 0; i < D; i++) begin
            if (b_q[W-D+i]) begin
                pp = pp ^ (AW'(a_q) << i);
            end
        end
        calc_acc = (acc_q << D) ^ pp;
    end

`ifdef OKA_MOD_REDUCE_EN
    localparam int            KW       = $clog2(AW);
    localparam logic [AW-1:0] POLY_EXT = AW'({1'b1, POLY});

    logic [KW-1:0] k_q, k_d;
    logic [AW-1:0] red_acc;

    // Long division, one quotient bit per cycle from degree 2W-2 down to W.
    always_comb begin
        red_acc = acc_q;
        if (acc_q[k_q]) begin
            red_acc = acc_q ^ (POLY_EXT << (k_q - KW'(W)));
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`ifdef OKA_MOD_REDUCE_EN
        k_d     = k_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = calc_acc;
                b_d   = b_q << D;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NDIG - 1)) begin
`ifdef OKA_MOD_REDUCE_EN
                    state_d = S_RED;
                    k_d     = KW'(AW - 1);
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef OKA_MOD_REDUCE_EN
            S_RED: begin
                acc_d = red_acc;
                k_d   = k_q - KW'(1);
                if (k_q == KW'(W)) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef OKA_MOD_REDUCE_EN
            k_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`ifdef OKA_MOD_REDUCE_EN
            k_q     <= k_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.y         = acc_q;
endmodule

// File: tb/tb_oka_clmul_seq.sv
// Directed checks of the W=8/D=2 multiplier plus a W=16 sweep over D in {1,4,16}.
module tb_oka_clmul_seq;
`ifdef OKA_MOD_REDUCE_EN
    localparam bit RED = 1'b1;
`else
    localparam bit RED = 1'b0;
`endif
    localparam int LAT8 = RED ? 11 : 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit sweep_go = 1'b0;

    oka_clmul_seq_if #(.W(8)) m_if ();
    oka_clmul_seq #(.W(8), .D(2), .POLY(8'h1B)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] clmul_ref(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [63:0] r = '0;
        for (int i = 0; i < w; i++) begin
            if (b[i]) r = r ^ (64'(a) << i);
        end
        return r;
    endfunction

    // Field multiply via repeated doubling (xtime), independent of the long-division form.
    function automatic logic [63:0] gfmul_ref(input logic [31:0] a, input logic [31:0] b,
                                              input int w, input logic [31:0] poly);
        logic [31:0] r    = '0;
        logic [31:0] mask = (32'd1 << w) - 32'd1;
        logic        hi;
        for (int i = w - 1; i >= 0; i--) begin
            hi = r[w-1];
            r  = (r << 1) & mask;
            if (hi)   r = r ^ poly;
            if (b[i]) r = r ^ a;
        end
        return 64'(r);
    endfunction

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        m_if.a = a;
        m_if.b = b;
        m_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        m_if.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit rdy_seen);
        lat = 0;
        rdy_seen = 1'b0;
        while (!m_if.out_valid && lat < 64) begin
            rdy_seen = rdy_seen | m_if.in_ready;
            @(posedge clk);
            #1;
            lat++;
        end
        rdy_seen = rdy_seen | m_if.in_ready;
    endtask

    task automatic release_out;
        @(negedge clk);
        m_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        m_if.out_ready = 1'b0;
    endtask

    task automatic op_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [14:0] exp);
        int lat;
        bit rs;
        start_op(a, b);
        check({tag, "_busy"}, m_if.busy, 1);
        wait_done(lat, rs);
        check({tag, "_y"}, m_if.y, exp);
        check({tag, "_lat"}, lat, LAT8);
        check({tag, "_inrdy"}, rs, 0);
        release_out();
        check({tag, "_idle_rdy"}, m_if.in_ready, 1);
        check({tag, "_idle_vld"}, m_if.out_valid, 0);
    endtask

    genvar g;
    for (g = 0; g < 3; g++) begin : g_sweep
        localparam int DD  = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        localparam int LAT = 16 / DD + (RED ? 15 : 0);
        bit done = 1'b0;

        oka_clmul_seq_if #(.W(16)) sif ();
        oka_clmul_seq #(.W(16), .D(DD), .POLY(16'h002B)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (sif)
        );

        initial begin
            logic [15:0] ra, rb;
            logic [63:0] exp;
            int lat;
            sif.a = '0;
            sif.b = '0;
            sif.in_valid = 1'b0;
            sif.out_ready = 1'b0;
            wait (sweep_go);
            for (int n = 0; n < 1000; n++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                exp = RED ? gfmul_ref(32'(ra), 32'(rb), 16, 32'h002B) : clmul_ref(32'(ra), 32'(rb), 16);
                @(negedge clk);
                sif.a = ra;
                sif.b = rb;
                sif.in_valid = 1'b1;
                @(posedge clk);
                #1;
                sif.in_valid = 1'b0;
                lat = 0;
                while (!sif.out_valid && lat < 100) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                check($sformatf("sweep_d%0d_y_%0h_%0h", DD, ra, rb), sif.y, exp);
                check($sformatf("sweep_d%0d_lat", DD), lat, LAT);
                @(negedge clk);
                sif.out_ready = 1'b1;
                @(posedge clk);
                #1;
                sif.out_ready = 1'b0;
            end
            done = 1'b1;
        end
    end

    initial begin
        int lat;
        bit rs;
        rst = 1'b1;
        m_if.a = '0;
        m_if.b = '0;
        m_if.in_valid = 1'b0;
        m_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", m_if.in_ready, 1);
        check("rst_out_valid", m_if.out_valid, 0);
        check("rst_busy", m_if.busy, 0);
        check("rst_y", m_if.y, 0);
        @(negedge clk);
        rst = 1'b0;

        op_check("ff_ff", 8'hFF, 8'hFF, RED ? 15'h0013 : 15'h5555);
        op_check("03_03", 8'h03, 8'h03, 15'h0005);
        op_check("80_80", 8'h80, 8'h80, RED ? 15'h009A : 15'h4000);
        op_check("57_83", 8'h57, 8'h83, RED ? 15'h00C1 : 15'h2B79);
        op_check("01_a5", 8'h01, 8'hA5, 15'h00A5);

        // Hold the result under backpressure while a stray operand is offered.
        start_op(8'h03, 8'h03);
        wait_done(lat, rs);
        check("bp_lat", lat, LAT8);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            m_if.in_valid = (c == 1);
            m_if.a = 8'hFF;
            m_if.b = 8'hFF;
            @(posedge clk);
            #1;
            check($sformatf("bp_vld_%0d", c), m_if.out_valid, 1);
            check($sformatf("bp_y_%0d", c), m_if.y, 15'h0005);
            check($sformatf("bp_rdy_%0d", c), m_if.in_ready, 0);
        end
        @(negedge clk);
        m_if.in_valid = 1'b1;
        m_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        m_if.out_ready = 1'b0;
        m_if.in_valid = 1'b0;
        check("bp_handoff_rdy", m_if.in_ready, 1);
        check("bp_handoff_vld", m_if.out_valid, 0);
        check("bp_handoff_busy", m_if.busy, 0);

        // Abort an operation two cycles after acceptance.
        start_op(8'h57, 8'h83);
        @(posedge clk);
        #1;
        check("abort_calc_busy", m_if.busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_in_ready", m_if.in_ready, 1);
        check("abort_out_valid", m_if.out_valid, 0);
        check("abort_y", m_if.y, 0);
        check("abort_busy", m_if.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        op_check("02_03", 8'h02, 8'h03, 15'h0006);

        sweep_go = 1'b1;
        for (int c = 0; c < 50000; c++) begin
            if (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) break;
            @(posedge clk);
        end
        check("sweep_done", {g_sweep[2].done, g_sweep[1].done, g_sweep[0].done}, 3'b111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
